// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
//   Sequencer sitting directly upstream of a ROWS x COLS PE array. A run has
//   three phases:
//     LOAD - accept one host cell per handshake and write it into the array
//            in raster order;
//     RUN  - broadcast PROCESS once per cycle until the programmed generation
//            count is reached or the array reports that nothing changed;
//     DUMP - read every cell back out in raster order through a
//            valid/ready stream.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   start, gens         begin a run (IDLE only); generation count latched on start
//   load_valid/_data    host cell stream in; load_ready while in LOAD
//   cmd                 broadcast PE command (NOP / WRITE / PROCESS)
//   rsel_i, csel_i      one-hot write select; state_in is the write data
//   rsel_o, csel_o      one-hot read select
//   state_or            OR of all PE state_out (only the selected PE drives it)
//   any_active          OR of all PE active flags for the current PROCESS cycle
//   out_valid/_data     readout stream out; out_ready from host
//   busy                controller is not idle
//   stable              last run ended because no PE changed
//   gen_count           PROCESS cycles issued in the current/last run
//   done                one-cycle pulse after the last readout cell
module pe_array_ctrl #(
  parameter int unsigned ROWS          = 8,
  parameter int unsigned COLS          = 8,
  parameter int unsigned GEN_W         = 16,
  parameter int unsigned PE_STATE_BITS = 1,
  parameter int unsigned PE_CMD_BITS   = 2,
  parameter logic [PE_CMD_BITS-1:0] PE_CMD_NOP     = PE_CMD_BITS'(0),
  parameter logic [PE_CMD_BITS-1:0] PE_CMD_WRITE   = PE_CMD_BITS'(1),
  parameter logic [PE_CMD_BITS-1:0] PE_CMD_PROCESS = PE_CMD_BITS'(2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [GEN_W-1:0]         gens,
  input  logic                     load_valid,
  input  logic [PE_STATE_BITS-1:0] load_data,
  output logic                     load_ready,
  output logic [PE_CMD_BITS-1:0]   cmd,
  output logic [ROWS-1:0]          rsel_i,
  output logic [COLS-1:0]          csel_i,
  output logic [PE_STATE_BITS-1:0] state_in,
  output logic [ROWS-1:0]          rsel_o,
  output logic [COLS-1:0]          csel_o,
  input  logic [PE_STATE_BITS-1:0] state_or,
  input  logic                     any_active,
  output logic                     out_valid,
  output logic [PE_STATE_BITS-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     stable,
  output logic [GEN_W-1:0]         gen_count,
  output logic                     done
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q, r_adv;
  logic [CW-1:0]     c_q, c_adv;
  logic [GEN_W-1:0]  gens_q;
  logic [GEN_W-1:0]  gen_count_q;
  logic [GEN_W-1:0]  gen_inc;
  logic              stable_q;
  logic              done_q;
  logic              at_last;

  assign at_last = (r_q == R_LAST) && (c_q == C_LAST);
  assign gen_inc = gen_count_q + GEN_W'(1);

  // Raster advance: column first, row on column wrap. The last cell clears
  // both so the next phase starts at (0,0) even for non-power-of-2 sizes.
  always_comb begin
    r_adv = r_q;
    c_adv = c_q;
    if (at_last) begin
      r_adv = '0;
      c_adv = '0;
    end else if (c_q == C_LAST) begin
      r_adv = r_q + RW'(1);
      c_adv = '0;
    end else begin
      c_adv = c_q + CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd        = PE_CMD_NOP;
    rsel_i     = '0;
    csel_i     = '0;
    state_in   = '0;
    rsel_o     = '0;
    csel_o     = '0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          cmd      = PE_CMD_WRITE;
          rsel_i   = ROWS'(1) << r_q;
          csel_i   = COLS'(1) << c_q;
          state_in = load_data;
          if (at_last) state_d = (gens_q == '0) ? S_DUMP : S_RUN;
        end
      end
      S_RUN: begin
        cmd = PE_CMD_PROCESS;
        // any_active reflects this cycle's PROCESS, so a quiet array ends
        // the run here; that check wins over reaching the count.
        if (!any_active) state_d = S_DUMP;
        else if (gen_inc == gens_q) state_d = S_DUMP;
      end
      S_DUMP: begin
        rsel_o    = ROWS'(1) << r_q;
        csel_o    = COLS'(1) << c_q;
        out_valid = 1'b1;
        out_data  = state_or;
        if (out_ready && at_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      gens_q      <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            gens_q      <= gens;
            r_q         <= '0;
            c_q         <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_q <= r_adv;
            c_q <= c_adv;
          end
        end
        S_RUN: begin
          gen_count_q <= gen_inc;
          if (!any_active) stable_q <= 1'b1;
        end
        S_DUMP: begin
          if (out_ready) begin
            r_q <= r_adv;
            c_q <= c_adv;
            if (at_last) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stable    = stable_q;
  assign gen_count = gen_count_q;
  assign done      = done_q;

endmodule
